// File: rtl/data_sync_if.sv
// Bundle of the signals crossing into the destination domain: the
// quasi-static source bus with its enable qualifier, and the synchronized
// bus with its one-cycle update pulse.
interface data_sync_if #(
    parameter int unsigned BUS_WIDTH = 8
);
    logic [BUS_WIDTH-1:0] unsync_bus;
    logic                 bus_enable;
    logic [BUS_WIDTH-1:0] sync_bus;
    logic                 enable_pulse;

    // Source side: drives the raw bus and enable, observes the results.
    modport master (
        output unsync_bus,
        output bus_enable,
        input  sync_bus,
        input  enable_pulse
    );

    // Receiver side: the data_sync stage itself.
    modport slave (
        input  unsync_bus,
        input  bus_enable,
        output sync_bus,
        output enable_pulse
    );
endinterface

// File: rtl/data_sync.sv
// Multi-bit CDC receiver. The enable is passed through a NUM_STAGES flop
// chain, its rising edge becomes a one-cycle pulse, and that pulse captures
// the (already stable) source bus exactly once per enable assertion.
module data_sync #(
    parameter int unsigned NUM_STAGES = 2,
    parameter int unsigned BUS_WIDTH  = 8
) (
    input  logic         CLK,
    input  logic         RST,
    data_sync_if.slave   bus
);

    logic [NUM_STAGES-1:0] r_sync_ff;
    logic                  r_pg_ff;
    logic [BUS_WIDTH-1:0]  r_sync_bus;
    logic                  r_enable_pulse;

    logic                  w_sync_en;
    logic                  w_pulse;

    // Enable synchronizer: bit 0 samples the asynchronous enable, the rest
    // shift it along so only the last stage is used by downstream logic.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync_ff <= '0;
        end else begin
            r_sync_ff <= {r_sync_ff[NUM_STAGES-2:0], bus.bus_enable};
        end
    end

    assign w_sync_en = r_sync_ff[NUM_STAGES-1];

    // Delayed copy of the synchronized enable for rising-edge detection.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_pg_ff <= 1'b0;
        end else begin
            r_pg_ff <= w_sync_en;
        end
    end

    // Rising edge of the synchronized enable; high for a single cycle.
    always_comb begin
        w_pulse = w_sync_en & ~r_pg_ff;
    end

    // Output registers: register the pulse and capture the bus on it only,
    // so bus changes without a fresh enable edge never reach the output.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_enable_pulse <= 1'b0;
            r_sync_bus     <= '0;
        end else begin
            r_enable_pulse <= w_pulse;
            if (w_pulse) begin
                r_sync_bus <= bus.unsync_bus;
            end
        end
    end

    assign bus.sync_bus     = r_sync_bus;
    assign bus.enable_pulse = r_enable_pulse;

endmodule
